llc_cmd_issuer: RTL and testbench

- Upstream feeder for the LLC stage. Accepts trace commands (operation code plus 32-bit address) on a valid/ready interface and buffers them in a small FIFO.
- Issues one command per cycle on the LLC `op`/`addr` inputs. When the LLC raises `hold`, the current command stays on the bus one extra cycle.
- Drives the idle code 8 whenever nothing is being issued. This replaces the file-reading stimulus loop with synthesizable sequencing logic.

---
 rtl/llc_cmd_issuer.sv | 171 +++++++++++++++++
 tb/tb_llc_cmd_issuer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_cmd_issuer.sv
// Trace command feeder for the LLC stage: buffers op/addr commands in a FIFO and
// issues one per cycle, stretching a command by one cycle when the LLC holds.
//
// state  | meaning
// S_IDLE | nothing presented, llc_op carries the idle code 8
// S_ISSUE| a freshly popped command is on llc_op/llc_addr
// S_HOLD | the same command re-presented for its one extra cycle
module llc_cmd_issuer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [3:0]        llc_op,
    output logic [ADDR_W-1:0] llc_addr,
    input  logic              llc_hold,
    output logic              idle,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0]       OP_IDLE = 4'd8;
    localparam logic [PW-1:0]    PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]        r_mem_op   [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [3:0]        r_llc_op;
    logic [ADDR_W-1:0] r_llc_addr;
    logic [CNT_W-1:0]  r_issued_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic w_empty;
    logic w_full;
    logic w_legal;
    logic w_xfer;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_go_idle;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_legal = (cmd_op <= 4'd6) || (cmd_op == 4'd9);

    // Ready comes only from registered pointers, so a pop in the same cycle
    // does not open a slot until the next cycle.
    assign cmd_ready = !w_full;
    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_push    = w_xfer && w_legal;
    assign w_drop    = w_xfer && !w_legal;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_go_idle   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (llc_hold) begin
                    w_state_nxt = S_HOLD;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_go_idle   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                // hold is ignored here so a command is never stretched twice
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_go_idle   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_go_idle   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr[AW-1:0]]   <= cmd_op;
            r_mem_addr[r_wr_ptr[AW-1:0]] <= cmd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_llc_op   <= OP_IDLE;
            r_llc_addr <= '0;
        end else if (w_pop) begin
            r_llc_op   <= r_mem_op[r_rd_ptr[AW-1:0]];
            r_llc_addr <= r_mem_addr[r_rd_ptr[AW-1:0]];
        end else if (w_go_idle) begin
            r_llc_op <= OP_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_pop && (r_issued_cnt != '1)) begin
                r_issued_cnt <= r_issued_cnt + CNT_ONE;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
        end
    end

    assign llc_op     = r_llc_op;
    assign llc_addr   = r_llc_addr;
    assign issued_cnt = r_issued_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign idle       = (r_state == S_IDLE) && w_empty;

endmodule

// File: tb/tb_llc_cmd_issuer.sv
// Bench for llc_cmd_issuer: directed scenarios with fixed expectations plus a
// randomized run compared against a queue-based model of the issue rules.
module tb_llc_cmd_issuer;
    localparam int DEPTH = 8;
    localparam int AW    = 32;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [3:0]    llc_op;
    logic [AW-1:0] llc_addr;
    logic          llc_hold;
    logic          idle;
    logic [CW-1:0] issued_cnt;
    logic [CW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // model: buffered commands, presented command, first-cycle flag, counters
    logic [35:0]   m_q[$];
    logic [3:0]    m_op;
    logic [AW-1:0] m_addr;
    bit            m_fresh;
    logic [CW-1:0] m_iss;
    logic [CW-1:0] m_drop;

    llc_cmd_issuer #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .llc_op(llc_op), .llc_addr(llc_addr), .llc_hold(llc_hold),
        .idle(idle), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit accept;
        logic [35:0] e;
        if (rst) begin
            m_q.delete();
            m_op = 4'd8; m_addr = '0; m_fresh = 0; m_iss = '0; m_drop = '0;
        end else begin
            accept = cmd_valid && (m_q.size() < DEPTH);
            if (m_op != 4'd8 && m_fresh && llc_hold) begin
                m_fresh = 0;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_op = e[35:32]; m_addr = e[31:0]; m_fresh = 1;
                if (m_iss != '1) m_iss = m_iss + 1'b1;
            end else begin
                m_op = 4'd8; m_fresh = 0;
            end
            if (accept) begin
                if (cmd_op <= 4'd6 || cmd_op == 4'd9) m_q.push_back({cmd_op, cmd_addr});
                else if (m_drop != '1) m_drop = m_drop + 1'b1;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] op, input logic [AW-1:0] a,
                        input logic h);
        cmd_valid = v; cmd_op = op; cmd_addr = a; llc_hold = h;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 4'd0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (llc_op !== 4'd8) begin bad++; $display("FAIL reset_op: got %0d want 8", llc_op); end
        total++; if (llc_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0h want 0", llc_addr); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", idle); end
        total++; if (issued_cnt !== '0 || drop_cnt !== '0) begin
            bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", issued_cnt, drop_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        tick(1'b1, 4'd0, 32'h1000, 1'b0);
        total++; if (llc_op !== 4'd8) begin bad++; $display("FAIL single_latency: got %0d want 8", llc_op); end
        tick(1'b0, 4'd0, '0, 1'b0);
        total++; if (llc_op !== 4'd0 || llc_addr !== 32'h1000) begin
            bad++; $display("FAIL single_issue: got %0d/%0h want 0/1000", llc_op, llc_addr);
        end
        tick(1'b0, 4'd0, '0, 1'b0);
        total++; if (llc_op !== 4'd8) begin bad++; $display("FAIL single_after: got %0d want 8", llc_op); end
        total++; if (issued_cnt !== 4'd1 || idle !== 1'b1) begin
            bad++; $display("FAIL single_end: got cnt=%0d idle=%b want 1/1", issued_cnt, idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  eo [6];
        logic [31:0] ea [6];
        eo = '{4'd8, 4'd1, 4'd2, 4'd3, 4'd9, 4'd8};
        ea = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) tick(1'b1, eo[i+1], ea[i+1], 1'b0);
            else tick(1'b0, 4'd0, '0, 1'b0);
            total++; if (llc_op !== eo[i]) begin
                bad++; $display("FAIL b2b_op[%0d]: got %0d want %0d", i, llc_op, eo[i]);
            end
            if (i >= 1 && i <= 4) begin
                total++; if (llc_addr !== ea[i]) begin
                    bad++; $display("FAIL b2b_addr[%0d]: got %0h want %0h", i, llc_addr, ea[i]);
                end
            end
        end
        total++; if (issued_cnt !== 4'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", issued_cnt); end
    endtask

    task automatic test_hold();
        logic [3:0] eo [6];
        logic [3:0] ec [9];
        eo = '{4'd8, 4'd1, 4'd2, 4'd2, 4'd3, 4'd8};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) tick(1'b1, 4'(i + 1), 32'(16 * (i + 1)), 1'b0);
            else tick(1'b0, 4'd0, '0, (i == 3));
            total++; if (llc_op !== eo[i]) begin
                bad++; $display("FAIL hold_op[%0d]: got %0d want %0d", i, llc_op, eo[i]);
            end
            if (i == 2 || i == 3) begin
                total++; if (llc_addr !== 32'h20) begin
                    bad++; $display("FAIL hold_addr[%0d]: got %0h want 20", i, llc_addr);
                end
            end
        end
        ec = '{4'd8, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd8, 4'd8};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 3) tick(1'b1, 4'(i + 4), 32'(16 * (i + 5)), 1'b1);
            else tick(1'b0, 4'd0, '0, 1'b1);
            total++; if (llc_op !== ec[i]) begin
                bad++; $display("FAIL hold_cont[%0d]: got %0d want %0d", i, llc_op, ec[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [35:0] pushed[$];
        logic [35:0] seen[$];
        logic [3:0]  op;
        logic [31:0] last_addr;
        int  idx = 0;
        int  errs = 0;
        bit  saw_low = 0;
        bit  saw_re = 0;
        last_addr = '1;
        do_reset();
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (llc_op !== 4'd8 && llc_addr !== last_addr) begin
                seen.push_back({llc_op, llc_addr});
                last_addr = llc_addr;
            end
            total++; if (cmd_ready !== (m_q.size() < DEPTH)) begin
                bad++; $display("FAIL full_ready[%0d]: got %b want %b", cyc, cmd_ready, m_q.size() < DEPTH);
            end
            if (!cmd_ready) saw_low = 1;
            else if (saw_low) saw_re = 1;
            op = 4'($urandom_range(0, 7));
            if (op == 4'd7) op = 4'd9;
            if (idx < 20) begin
                if (cmd_ready) begin
                    pushed.push_back({op, 32'h100 + 32'(idx)});
                    idx++;
                end
                tick(1'b1, op, 32'h100 + 32'(idx - (cmd_ready ? 1 : 0)), 1'b1);
            end else begin
                tick(1'b0, 4'd0, '0, 1'b1);
            end
        end
        total++; if (idx != 20) begin bad++; $display("FAIL full_push_timeout: got %0d want 20", idx); end
        total++; if (!saw_low) begin bad++; $display("FAIL full_ready_drop: got never-low want low-once"); end
        total++; if (!saw_re) begin bad++; $display("FAIL full_ready_back: got stays-low want reasserted"); end
        total++; if (seen.size() != pushed.size()) begin
            bad++; $display("FAIL full_count: got %0d want %0d", seen.size(), pushed.size());
        end
        for (int i = 0; i < seen.size() && i < pushed.size(); i++)
            if (seen[i] !== pushed[i]) errs++;
        total++; if (errs != 0) begin bad++; $display("FAIL full_order: got %0d wrong want 0", errs); end
    endtask

    task automatic test_illegal();
        logic [3:0] ops [4];
        int n4 = 0;
        int other = 0;
        ops = '{4'd7, 4'd4, 4'd8, 4'd15};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ill_ready[%0d]: got %b want 1", i, cmd_ready); end
            if (i < 4) tick(1'b1, ops[i], 32'h700 + 32'(i), 1'b0);
            else tick(1'b0, 4'd0, '0, 1'b0);
            if (llc_op === 4'd4) n4++;
            else if (llc_op !== 4'd8) other++;
        end
        total++; if (n4 != 1 || other != 0) begin
            bad++; $display("FAIL ill_issue: got op4=%0d other=%0d want 1/0", n4, other);
        end
        total++; if (drop_cnt !== 4'd3 || issued_cnt !== 4'd1) begin
            bad++; $display("FAIL ill_cnt: got drop=%0d iss=%0d want 3/1", drop_cnt, issued_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int leaked = 0;
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 4'(i % 7), 32'h900 + 32'(i), 1'b1);
        total++; if (llc_op !== 4'd3 || llc_addr !== 32'h903) begin
            bad++; $display("FAIL mid_pre: got %0d/%0h want 3/903", llc_op, llc_addr);
        end
        rst = 1'b1;
        tick(1'b0, 4'd0, '0, 1'b1);
        rst = 1'b0;
        total++; if (llc_op !== 4'd8 || idle !== 1'b1) begin
            bad++; $display("FAIL mid_reset: got op=%0d idle=%b want 8/1", llc_op, idle);
        end
        total++; if (issued_cnt !== '0 || drop_cnt !== '0) begin
            bad++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", issued_cnt, drop_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 4'd0, '0, 1'b0);
            if (llc_op !== 4'd8) leaked++;
        end
        total++; if (leaked != 0) begin bad++; $display("FAIL mid_replay: got %0d cycles want 0", leaked); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = (op % 4'd7);
            rst = ($urandom_range(0, 199) == 0);
            tick($urandom_range(0, 9) < 7, op, $urandom, $urandom_range(0, 1) == 1);
            rst = 1'b0;
            total++; if (llc_op !== m_op || (m_op != 4'd8 && llc_addr !== m_addr)) begin
                bad++; $display("FAIL rnd_out[%0d]: got %0d/%0h want %0d/%0h", i, llc_op, llc_addr, m_op, m_addr);
            end
            total++; if (cmd_ready !== (m_q.size() < DEPTH) || idle !== (m_op == 4'd8 && m_q.size() == 0)) begin
                bad++; $display("FAIL rnd_flags[%0d]: got rdy=%b idle=%b want %b/%b", i, cmd_ready, idle,
                                m_q.size() < DEPTH, m_op == 4'd8 && m_q.size() == 0);
            end
            total++; if (issued_cnt !== m_iss || drop_cnt !== m_drop) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, issued_cnt, drop_cnt, m_iss, m_drop);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; llc_hold = 1'b0;
        m_op = 4'd8; m_addr = '0; m_fresh = 0; m_iss = '0; m_drop = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_full();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
